// File: rtl/peripheral_wb_pkg.sv
// Shared types and constants for the Wishbone UART transmit path.
package peripheral_wb_pkg;

   // Serializer FSM encoding, visible to the LSR/IIR logic through tstate.
   typedef enum logic [2:0] {
      TxIdle   = 3'd0,
      TxPop    = 3'd1,
      TxStart  = 3'd2,
      TxData   = 3'd3,
      TxParity = 3'd4,
      TxStop   = 3'd5
   } uart_tx_state_t;

   // LCR bit positions (bits [1:0] hold the word length code).
   localparam int unsigned LcrStopBit  = 2;
   localparam int unsigned LcrParEnBit = 3;
   localparam int unsigned LcrEvenBit  = 4;
   localparam int unsigned LcrStickBit = 5;
   localparam int unsigned LcrBreakBit = 6;

   // Enable ticks per bit and per stop period.
   localparam int unsigned BitTicks    = 16;
   localparam int unsigned StopTicks1  = 16;
   localparam int unsigned StopTicks15 = 24;
   localparam int unsigned StopTicks2  = 32;

   // Last tick index of the stop period; 1.5 stop bits only apply to 5-bit words.
   function automatic logic [4:0] stop_last_tick(input logic stop2, input logic wlen5);
      if (!stop2) return 5'(StopTicks1 - 1);
      if (wlen5) return 5'(StopTicks15 - 1);
      return 5'(StopTicks2 - 1);
   endfunction

endpackage

// File: rtl/peripheral_raminfr_wb.sv
// Inferred dual-port RAM: synchronous write, asynchronous read.
module peripheral_raminfr_wb #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Storage write port.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/peripheral_uart_tfifo_wb.sv
// TX FIFO: owns pointers, occupancy count and the sticky overrun flag.
module peripheral_uart_tfifo_wb #(
   parameter int unsigned FIFO_WIDTH     = 8,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned FIFO_POINTER_W = 4,
   parameter int unsigned FIFO_COUNTER_W = 5
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic                      i_clear,
   input  logic [FIFO_WIDTH-1:0]     i_data,
   output logic [FIFO_WIDTH-1:0]     o_data,
   output logic [FIFO_COUNTER_W-1:0] o_count,
   output logic                      o_overrun
);

   logic [FIFO_POINTER_W-1:0] r_top, r_bottom;
   logic [FIFO_COUNTER_W-1:0] r_count;
   logic                      r_overrun;
   logic                      w_full, w_empty, w_do_pop, w_do_push;

   assign w_full    = (r_count == FIFO_COUNTER_W'(FIFO_DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !w_empty;
   // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
   assign w_do_push = i_push && (!w_full || w_do_pop);

   peripheral_raminfr_wb #(
      .ADDR_W (FIFO_POINTER_W),
      .DATA_W (FIFO_WIDTH),
      .DEPTH  (FIFO_DEPTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_do_push && !i_clear),
      .i_waddr (r_top),
      .i_wdata (i_data),
      .i_raddr (r_bottom),
      .o_rdata (o_data)
   );

   // Pointer, count and overrun bookkeeping; clear wins over push/pop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_top     <= '0;
         r_bottom  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else if (i_clear) begin
         r_top     <= '0;
         r_bottom  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_do_push) r_top <= r_top + FIFO_POINTER_W'(1);
         if (w_do_pop) r_bottom <= r_bottom + FIFO_POINTER_W'(1);
         if (w_do_push && !w_do_pop) r_count <= r_count + FIFO_COUNTER_W'(1);
         else if (!w_do_push && w_do_pop) r_count <= r_count - FIFO_COUNTER_W'(1);
         if (i_push && !w_do_push) r_overrun <= 1'b1;
      end
   end

   assign o_count   = r_count;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/peripheral_uart_transmitter_wb.sv
// UART transmit path: TX FIFO plus the serializer FSM driving stx_pad_o.
module peripheral_uart_transmitter_wb
   import peripheral_wb_pkg::*;
#(
   parameter int unsigned FIFO_WIDTH     = 8,
   parameter int unsigned FIFO_DEPTH     = 16,
   parameter int unsigned FIFO_POINTER_W = 4,
   parameter int unsigned FIFO_COUNTER_W = 5
) (
   input  logic                      clk,
   input  logic                      wb_rst_ni,
   input  logic [7:0]                lcr,
   input  logic                      enable,
   input  logic                      tx_push,
   input  logic [FIFO_WIDTH-1:0]     tx_data,
   input  logic                      tx_fifo_reset,
   output logic                      stx_pad_o,
   output logic [2:0]                tstate,
   output logic [FIFO_COUNTER_W-1:0] tf_count,
   output logic                      tf_overrun,
   output logic                      tx_busy
);

   localparam logic [4:0] BitLast = 5'(BitTicks - 1);

   uart_tx_state_t        r_state, w_state_next;
   logic [4:0]            r_tick, w_tick_next;
   logic [7:0]            r_shift, w_shift_next;
   logic [3:0]            r_bits, w_bits_next;
   logic                  r_par_en, r_parity, r_wlen5;
   logic                  w_pop, w_fifo_empty, w_par_bit, w_line, w_unused;
   logic [FIFO_WIDTH-1:0] w_fifo_head;
   logic [7:0]            w_masked;
   logic [4:0]            w_stop_last;

   assign w_unused = lcr[7];

   peripheral_uart_tfifo_wb #(
      .FIFO_WIDTH     (FIFO_WIDTH),
      .FIFO_DEPTH     (FIFO_DEPTH),
      .FIFO_POINTER_W (FIFO_POINTER_W),
      .FIFO_COUNTER_W (FIFO_COUNTER_W)
   ) u_tfifo (
      .i_clk     (clk),
      .i_rst_n   (wb_rst_ni),
      .i_push    (tx_push),
      .i_pop     (w_pop),
      .i_clear   (tx_fifo_reset),
      .i_data    (tx_data),
      .o_data    (w_fifo_head),
      .o_count   (tf_count),
      .o_overrun (tf_overrun)
   );

   assign w_fifo_empty = (tf_count == '0);
   // Drop bits above the configured word length before computing parity.
   assign w_masked     = w_fifo_head & (8'hFF >> (2'd3 - lcr[1:0]));
   assign w_par_bit    = lcr[LcrStickBit] ? ~lcr[LcrEvenBit]
                       : (lcr[LcrEvenBit] ? ^w_masked : ~^w_masked);
   assign w_stop_last  = stop_last_tick(lcr[LcrStopBit], r_wlen5);

   // Next-state logic; the whole FSM only moves on a baud enable tick.
   always_comb begin
      w_state_next = r_state;
      w_tick_next  = r_tick;
      w_shift_next = r_shift;
      w_bits_next  = r_bits;
      w_pop        = 1'b0;
      if (enable) begin
         w_tick_next = r_tick + 5'd1;
         unique case (r_state)
            TxIdle: begin
               w_tick_next = '0;
               if (!w_fifo_empty) w_state_next = TxPop;
            end
            TxPop: begin
               w_tick_next = '0;
               // FIFO may have been cleared since STOP decided to come here.
               if (w_fifo_empty) begin
                  w_state_next = TxIdle;
               end else begin
                  w_pop        = 1'b1;
                  w_shift_next = w_fifo_head;
                  w_bits_next  = 4'd5 + {2'b00, lcr[1:0]};
                  w_state_next = TxStart;
               end
            end
            TxStart: begin
               if (r_tick == BitLast) begin
                  w_tick_next  = '0;
                  w_state_next = TxData;
               end
            end
            TxData: begin
               if (r_tick == BitLast) begin
                  w_tick_next = '0;
                  if (r_bits == 4'd1) begin
                     w_state_next = r_par_en ? TxParity : TxStop;
                  end else begin
                     w_shift_next = {1'b0, r_shift[7:1]};
                     w_bits_next  = r_bits - 4'd1;
                  end
               end
            end
            TxParity: begin
               if (r_tick == BitLast) begin
                  w_tick_next  = '0;
                  w_state_next = TxStop;
               end
            end
            TxStop: begin
               if (r_tick == w_stop_last) begin
                  w_tick_next  = '0;
                  w_state_next = w_fifo_empty ? TxIdle : TxPop;
               end
            end
            default: begin
               w_tick_next  = '0;
               w_state_next = TxIdle;
            end
         endcase
      end
   end

   // FSM, tick counter and shift register state.
   always_ff @(posedge clk or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state <= TxIdle;
         r_tick  <= '0;
         r_shift <= '0;
         r_bits  <= '0;
      end else begin
         r_state <= w_state_next;
         r_tick  <= w_tick_next;
         r_shift <= w_shift_next;
         r_bits  <= w_bits_next;
      end
   end

   // Per-frame snapshot of parity and word-length settings taken at POP.
   always_ff @(posedge clk or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_par_en <= 1'b0;
         r_parity <= 1'b0;
         r_wlen5  <= 1'b0;
      end else if (w_pop) begin
         r_par_en <= lcr[LcrParEnBit];
         r_parity <= w_par_bit;
         r_wlen5  <= (lcr[1:0] == 2'b00);
      end
   end

   // Serial line level for the current state.
   always_comb begin
      w_line = 1'b1;
      unique case (r_state)
         TxStart:  w_line = 1'b0;
         TxData:   w_line = r_shift[0];
         TxParity: w_line = r_parity;
         default:  w_line = 1'b1;
      endcase
   end

   assign stx_pad_o = lcr[LcrBreakBit] ? 1'b0 : w_line;
   assign tstate    = r_state;
   assign tx_busy   = (r_state != TxIdle);

endmodule

// File: tb/tb_peripheral_uart_transmitter_wb.sv
// Directed bench for the UART transmit path: frame tables plus corner sequences.
module tb_peripheral_uart_transmitter_wb;

   logic       clk = 1'b0;
   logic       wb_rst_ni;
   logic [7:0] lcr;
   logic       enable;
   logic       tx_push;
   logic [7:0] tx_data;
   logic       tx_fifo_reset;
   logic       stx_pad_o;
   logic [2:0] tstate;
   logic [4:0] tf_count;
   logic       tf_overrun;
   logic       tx_busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   peripheral_uart_transmitter_wb dut (
      .clk           (clk),
      .wb_rst_ni     (wb_rst_ni),
      .lcr           (lcr),
      .enable        (enable),
      .tx_push       (tx_push),
      .tx_data       (tx_data),
      .tx_fifo_reset (tx_fifo_reset),
      .stx_pad_o     (stx_pad_o),
      .tstate        (tstate),
      .tf_count      (tf_count),
      .tf_overrun    (tf_overrun),
      .tx_busy       (tx_busy)
   );

   // levels[i] is the line level of the i-th bit period (start, data, parity).
   typedef struct {
      logic [7:0]  lcr;
      logic [7:0]  data;
      logic [15:0] levels;
      int          n;
      int          stop;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] d);
      tx_push = 1'b1;
      tx_data = d;
      @(negedge clk);
      tx_push = 1'b0;
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget, input string name);
      int i;
      i = 0;
      while (tstate !== st && i < budget) begin
         @(negedge clk);
         i++;
      end
      check(name, {29'd0, tstate}, {29'd0, st});
   endtask

   task automatic run_vec(input int k);
      vec_t       v;
      logic       got;
      logic       stop_ok;
      logic       exp_lvl;
      logic [2:0] st_last;
      v = vecs[k];
      lcr = v.lcr;
      push_byte(v.data);
      wait_state(3'd1, 20, $sformatf("v%0d reach POP", k));
      for (int i = 0; i < v.n; i++) begin
         exp_lvl = v.levels[i];
         got = exp_lvl;
         for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            if (stx_pad_o !== exp_lvl) got = stx_pad_o;
         end
         check($sformatf("v%0d level %0d", k, i), {31'd0, got}, {31'd0, exp_lvl});
      end
      stop_ok = 1'b1;
      st_last = 3'd5;
      for (int t = 0; t < v.stop; t++) begin
         @(negedge clk);
         if (stx_pad_o !== 1'b1) stop_ok = 1'b0;
         st_last = tstate;
      end
      check($sformatf("v%0d stop high", k), {31'd0, stop_ok}, 32'd1);
      check($sformatf("v%0d in STOP at last stop tick", k), {29'd0, st_last}, 32'd5);
      @(negedge clk);
      check($sformatf("v%0d IDLE after stop", k), {29'd0, tstate}, 32'd0);
      check($sformatf("v%0d fifo empty", k), {27'd0, tf_count}, 32'd0);
   endtask

   initial begin
      logic [7:0] cap;
      logic       ok;
      int         k;

      vecs[0] = '{8'h03, 8'hA5, 16'h014A, 9, 16}; // 8N1
      vecs[1] = '{8'h1A, 8'h35, 16'h006A, 9, 16}; // 7E1, parity 0
      vecs[2] = '{8'h0A, 8'h35, 16'h016A, 9, 16}; // 7O1, parity 1
      vecs[3] = '{8'h2A, 8'h35, 16'h016A, 9, 16}; // stick, parity 1
      vecs[4] = '{8'h04, 8'h1F, 16'h003E, 6, 24}; // 5-bit, 1.5 stop
      vecs[5] = '{8'h05, 8'h1F, 16'h003E, 7, 32}; // 6-bit, 2 stop

      wb_rst_ni = 1'b0;
      lcr = 8'h03;
      enable = 1'b1;
      tx_push = 1'b0;
      tx_data = 8'h00;
      tx_fifo_reset = 1'b0;
      repeat (3) @(negedge clk);
      check("reset stx", {31'd0, stx_pad_o}, 32'd1);
      check("reset tstate", {29'd0, tstate}, 32'd0);
      check("reset tf_count", {27'd0, tf_count}, 32'd0);
      check("reset tf_overrun", {31'd0, tf_overrun}, 32'd0);
      check("reset tx_busy", {31'd0, tx_busy}, 32'd0);
      wb_rst_ni = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(i);

      // Break mid-DATA: line forced low, frame keeps its place.
      lcr = 8'h03;
      push_byte(8'hA5);
      push_byte(8'h5A);
      wait_state(3'd1, 20, "brk reach POP");
      repeat (24) @(negedge clk);
      check("brk bit0 before", {31'd0, stx_pad_o}, 32'd1);
      check("brk count before", {27'd0, tf_count}, 32'd1);
      lcr = 8'h43;
      #1;
      check("brk line low", {31'd0, stx_pad_o}, 32'd0);
      check("brk tstate DATA", {29'd0, tstate}, 32'd3);
      repeat (4) @(negedge clk);
      lcr = 8'h03;
      #1;
      check("brk resume bit0", {31'd0, stx_pad_o}, 32'd1);
      check("brk count after", {27'd0, tf_count}, 32'd1);
      @(negedge clk);
      wait_state(3'd0, 600, "brk back to IDLE");

      // Overflow with the FSM stalled, then back-to-back drain.
      enable = 1'b0;
      for (int i = 0; i < 16; i++) push_byte(8'(i));
      check("ovf count full", {27'd0, tf_count}, 32'd16);
      check("ovf not yet", {31'd0, tf_overrun}, 32'd0);
      push_byte(8'h10);
      check("ovf count held", {27'd0, tf_count}, 32'd16);
      check("ovf flag", {31'd0, tf_overrun}, 32'd1);
      enable = 1'b1;
      k = 0;
      cap = 8'h00;
      while (tstate !== 3'd0 || k == 0) begin
         @(negedge clk);
         k++;
         for (int b = 0; b < 8; b++)
            if (k == 2433 + 16 * b + 8) cap[b] = stx_pad_o;
         if (k > 3000) break;
      end
      check("drain length", k, 32'd2577);
      check("last frame byte", {24'd0, cap}, 32'h0F);
      check("drain fifo empty", {27'd0, tf_count}, 32'd0);
      check("overrun sticky", {31'd0, tf_overrun}, 32'd1);
      tx_fifo_reset = 1'b1;
      @(negedge clk);
      tx_fifo_reset = 1'b0;
      check("fifo reset clears overrun", {31'd0, tf_overrun}, 32'd0);

      // Async reset mid-frame.
      push_byte(8'h00);
      push_byte(8'h00);
      wait_state(3'd1, 20, "rst reach POP");
      repeat (24) @(negedge clk);
      check("rst data low", {31'd0, stx_pad_o}, 32'd0);
      wb_rst_ni = 1'b0;
      #1;
      check("rst stx", {31'd0, stx_pad_o}, 32'd1);
      check("rst count", {27'd0, tf_count}, 32'd0);
      check("rst tstate", {29'd0, tstate}, 32'd0);
      check("rst busy", {31'd0, tx_busy}, 32'd0);
      @(negedge clk);
      wb_rst_ni = 1'b1;
      ok = 1'b1;
      repeat (400) begin
         @(negedge clk);
         if (stx_pad_o !== 1'b1 || tstate !== 3'd0) ok = 1'b0;
      end
      check("rst stays idle", {31'd0, ok}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/peripheral_uart_transmitter_wb.md
Name: peripheral_uart_transmitter_wb

Overview:
UART transmit path for the Wishbone UART peripheral. It holds a 16-deep, 8-bit TX FIFO written from the bus side, and a serializer FSM that pops bytes and drives the serial line. Frame format comes from the LCR. Bit timing comes from the shared 16x baud enable pulse, so each bit lasts 16 enable ticks. It is the counterpart of the receiver/RX FIFO path and reports TX FIFO count and FSM state for the LSR/IIR logic.

Parameters:
FIFO_WIDTH, 8, TX data width
FIFO_DEPTH, 16, TX FIFO entries
FIFO_POINTER_W, 4, FIFO pointer width
FIFO_COUNTER_W, 5, FIFO count width (must hold 0..FIFO_DEPTH)

Ports:
clk  in  1  system clock
wb_rst_ni  in  1  asynchronous active-low reset
lcr  in  8  [1:0] word length 5/6/7/8; [2] stop select; [3] parity enable; [4] even parity; [5] stick parity; [6] break
enable  in  1  16x baud tick, one clk wide
tx_push  in  1  write tx_data into FIFO
tx_data  in  8  byte from bus
tx_fifo_reset  in  1  synchronous FIFO clear
stx_pad_o  out  1  serial output, idle high
tstate  out  3  FSM state encoding
tf_count  out  5  TX FIFO occupancy
tf_overrun  out  1  sticky: push attempted while full
tx_busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, wb_rst_ni=0) sets these values: stx_pad_o=1, tstate=IDLE(0), tf_count=0, tf_overrun=0, tx_busy=0, tick counter=0, and FIFO pointers=0. Reset aborts any frame immediately.
- FIFO push/pop, count, and overflow:
  - On a push with count<16: write at top, top+1, count+1.
  - On a push with count==16: data dropped, count holds at 16, tf_overrun<=1.
  - Push and pop in the same cycle: both take effect and count is unchanged. When full, this write is accepted.
  - Pointers wrap modulo 16.
- tx_fifo_reset: empties the FIFO (pointers and count to 0) and clears tf_overrun. The frame in progress completes from the shift register.
- FIFO read data is combinational from bottom.
- FSM states: IDLE=0, POP=1, START=2, DATA=3, PARITY=4, STOP=5.
  - IDLE: when tf_count!=0, go to POP. stx_pad_o=1.
  - POP: latch FIFO head into an 8-bit shift register and pulse the internal pop for one clk. Latch the bit count (5+lcr[1:0]) and compute the parity bit. Clear the tick counter. Go to START.
  - START: line=0 for 16 enable ticks, then go to DATA.
  - DATA: line=shift[0], LSB first. Every 16 ticks, shift right and decrement the bit count. After the last bit, go to PARITY if lcr[3]=1, else go to STOP.
  - PARITY: line=parity bit for 16 ticks, then go to STOP.
  - STOP: line=1 for the stop duration, then go to POP if the FIFO is non-empty (back-to-back frames, no idle gap), else go to IDLE.
- Stop duration:
  - 16 ticks if lcr[2]=0.
  - 24 ticks if lcr[2]=1 and word length is 5.
  - 32 ticks otherwise.
- Parity bit:
  - Computed over the masked word.
  - Odd (lcr[4]=0): ~^data. Even (lcr[4]=1): ^data.
  - Stick (lcr[5]=1): parity = ~lcr[4].
- The tick counter is 5 bits. It advances only on enable=1 and clears on each state advance.
- The LCR is sampled live, except that word length and parity are captured in POP. Software changes to the LCR mid-frame take effect on the next frame.
- Break (lcr[6]=1): stx_pad_o forced to 0 combinationally. The FSM keeps running and consumes bytes normally.
- tx_busy = (tstate!=IDLE).

Decomposition:
- peripheral_wb_pkg holds:
  - the state enum (uart_tx_state_t, 3 bits)
  - LCR bit index constants
  - the bit-tick count (16)
  - the stop tick counts (16/24/32)
- One sub-module: peripheral_uart_tfifo_wb, the 8-bit TX FIFO.
  - It instantiates peripheral_raminfr_wb for storage.
  - It owns count and overrun.
- The FSM and the parity/stop logic live in the top module.

Test Plan:
- 8N1 (lcr=0x03), enable every clk, push 0xA5:
  - stx_pad_o must be 0,1,0,1,0,0,1,0,1,1, each level held 16 clks.
  - Frame = 160 clks after POP. Line returns to 1 and tstate=IDLE.
- 7E1 (lcr=0x1A), push 0x35:
  - Data bits 1,0,1,0,1,1,0, then parity 0, then stop 1.
  - Same byte with lcr=0x0A (odd): parity 1.
  - Stick, lcr=0x2A: parity 1.
- 5-bit, lcr[2]=1 (lcr=0x04), push 0x1F: stop high for exactly 24 ticks. Then 6-bit (lcr=0x05): stop 32 ticks.
- enable=0, push 17 bytes 0x00..0x10:
  - tf_count=16, tf_overrun=1, 0x10 dropped.
  - Release enable: 16 frames back-to-back with no idle clk between STOP and START.
  - tx_fifo_reset clears overrun.
- Mid-DATA assert lcr[6]: line=0 immediately. Deassert: line resumes the current bit, and the byte count consumed is unchanged.
- Push 2 bytes, pull wb_rst_ni low during DATA of byte 1:
  - Immediately stx_pad_o=1, tf_count=0, tstate=0.
  - After release, nothing transmits.
